// File: rtl/rr_enc_pkg.sv
// ============================================================================
// rr_enc_pkg : shared constants and state type for the round-robin encoder
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rr_enc_pkg;

   localparam int N_DEFAULT = 32;
   localparam int W_DEFAULT = $clog2(N_DEFAULT);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage : rr_enc_pkg

`default_nettype wire

// File: rtl/rr_find_first.sv
// ============================================================================
// rr_find_first : first set request at or above start, wrapping to bit 0
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rr_find_first
   import rr_enc_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int W = W_DEFAULT
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found
);

   logic         w_hi_found;
   logic [W-1:0] w_hi_idx;
   logic [W-1:0] w_lo_idx;

   // Downward scans so the lowest qualifying index is the one left standing.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_lo_idx = W'(i);
            if (i >= int'(start)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = W'(i);
            end
         end
      end
   end

   assign idx   = w_hi_found ? w_hi_idx : w_lo_idx;
   assign found = |req;

endmodule : rr_find_first

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
// ============================================================================
// rr_priority_encoder : registered round-robin grant with valid/ready output
// Revision            : 1.0
// ============================================================================
`default_nettype none

module rr_priority_encoder
   import rr_enc_pkg::*;
#(
   parameter int N = N_DEFAULT,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam logic [W-1:0] c_LAST_IDX = W'(N - 1);
   localparam logic [N-1:0] c_ONE      = {{(N-1){1'b0}}, 1'b1};

   state_e       state_q, state_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] onehot_q, onehot_d;

   logic         w_handshake;
   logic         w_load;
   logic [W-1:0] w_next_ptr;
   logic [W-1:0] w_start;
   logic [W-1:0] w_found_idx;
   logic         w_found;

   assign w_handshake = (state_q == HOLD) && out_ready;
   assign w_next_ptr  = (idx_q == c_LAST_IDX) ? '0 : idx_q + 1'b1;
   // A back-to-back load must search from the pointer this handshake produces.
   assign w_start     = w_handshake ? w_next_ptr : ptr_q;
   assign w_load      = en && w_found && ((state_q == IDLE) || out_ready);

   rr_find_first #(
      .N (N),
      .W (W)
   ) u_find (
      .req   (req),
      .start (w_start),
      .idx   (w_found_idx),
      .found (w_found)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
      if (w_handshake) begin
         ptr_d = w_next_ptr;
      end
      if (w_load) begin
         state_d  = HOLD;
         idx_d    = w_found_idx;
         onehot_d = c_ONE << w_found_idx;
      end else if (w_handshake) begin
         state_d  = IDLE;
         onehot_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         onehot_q <= onehot_d;
      end
   end

   assign out_idx    = idx_q;
   assign out_onehot = onehot_q;
   assign out_valid  = (state_q == HOLD);

endmodule : rr_priority_encoder

`default_nettype wire

// File: tb/tb_rr_priority_encoder.sv
// ============================================================================
// tb_rr_priority_encoder : directed and random checks against a rotation model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_rr_priority_encoder;

   localparam int N = 32;
   localparam int W = 5;

   logic         clk;
   logic         reset;
   logic         en;
   logic [N-1:0] req;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic         out_valid;
   logic         out_ready;

   int n_checks;
   int n_errors;

   // Reference state: pending grant, its index, and the rotation start point.
   bit m_valid;
   int m_idx;
   int m_ptr;

   rr_priority_encoder #(
      .N (N),
      .W (W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .req        (req),
      .out_idx    (out_idx),
      .out_onehot (out_onehot),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rr_first(logic [N-1:0] r, int s);
      for (int k = 0; k < N; k++) begin
         if (r[(s + k) % N]) return (s + k) % N;
      end
      return -1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(string tag);
      logic [N-1:0] exp_oh;
      exp_oh = m_valid ? (32'd1 << m_idx) : '0;
      chk({tag, ".valid"},  {31'd0, out_valid}, {31'd0, m_valid});
      chk({tag, ".idx"},    {27'd0, out_idx},   m_idx[31:0]);
      chk({tag, ".onehot"}, out_onehot,         exp_oh);
   endtask

   // Advance one clock, update the model from the inputs seen at the edge.
   task automatic step(string tag);
      logic [N-1:0] r;
      logic         e;
      logic         rd;
      bit           hs;
      bit           ld;
      int           s;
      r  = req;
      e  = en;
      rd = out_ready;
      @(posedge clk);
      hs = m_valid && rd;
      ld = e && (r != '0) && (!m_valid || rd);
      s  = hs ? (m_idx + 1) % N : m_ptr;
      if (hs) m_ptr = (m_idx + 1) % N;
      if (ld) begin
         m_idx   = rr_first(r, s);
         m_valid = 1'b1;
      end else if (hs) begin
         m_valid = 1'b0;
      end
      #1;
      chk_model(tag);
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      chk_model("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int rot_exp[6];
      int fair_exp[4];
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b0;
      en        = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      model_reset();
      #2;
      do_reset();

      // Asynchronous reset in the middle of a held grant
      en = 1'b1; req = 32'h20; out_ready = 1'b0;
      step("hold5");
      chk("hold5.idx", {27'd0, out_idx}, 32'd5);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async_rst.valid",  {31'd0, out_valid}, 32'd0);
      chk("async_rst.idx",    {27'd0, out_idx},   32'd0);
      chk("async_rst.onehot", out_onehot,         32'd0);
      #2;
      reset = 1'b0;
      req = 32'h10;
      step("post_rst");
      chk("post_rst.onehot", out_onehot, 32'h10);

      // Rotation with continuous acceptance
      do_reset();
      req = 32'h111; en = 1'b1; out_ready = 1'b1;
      rot_exp = '{0, 4, 8, 0, 4, 8};
      for (int i = 0; i < 6; i++) begin
         step("rot");
         chk("rot.idx", {27'd0, out_idx}, rot_exp[i][31:0]);
         chk("rot.valid", {31'd0, out_valid}, 32'd1);
      end

      // Backpressure holds the grant while req wanders
      do_reset();
      req = 32'h08; out_ready = 1'b0;
      step("bp_load");
      req = 32'h08; step("bp0");
      req = 32'hF0; step("bp1");
      req = 32'h00; step("bp2");
      chk("bp.idx", {27'd0, out_idx}, 32'd3);
      chk("bp.onehot", out_onehot, 32'h08);
      step("bp3");
      out_ready = 1'b1;
      step("bp_accept");
      chk("bp_accept.valid", {31'd0, out_valid}, 32'd0);
      chk("bp_accept.idx", {27'd0, out_idx}, 32'd3);
      req = 32'h21; out_ready = 1'b0;
      step("bp_ptr4");
      chk("bp_ptr4.idx", {27'd0, out_idx}, 32'd5);

      // Wrap-around from index 31
      do_reset();
      req = 32'h4000_0000; out_ready = 1'b0;
      step("wrap30");
      req = '0; out_ready = 1'b1;
      step("wrap_idle");
      req = 32'h8000_0001; out_ready = 1'b0;
      step("wrap31");
      chk("wrap31.idx", {27'd0, out_idx}, 32'd31);
      out_ready = 1'b1;
      step("wrap0");
      chk("wrap0.idx", {27'd0, out_idx}, 32'd0);

      // Enable gating
      do_reset();
      en = 1'b0; req = 32'hFF; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("en_off");
         chk("en_off.valid", {31'd0, out_valid}, 32'd0);
      end
      en = 1'b1;
      step("en_on");
      chk("en_on.idx", {27'd0, out_idx}, 32'd0);
      chk("en_on.valid", {31'd0, out_valid}, 32'd1);
      en = 1'b0; out_ready = 1'b0;
      step("en_off_hold");
      chk("en_off_hold.valid", {31'd0, out_valid}, 32'd1);

      // Fairness between two persistent requesters, and a lone request
      do_reset();
      en = 1'b1; req = 32'h3; out_ready = 1'b1;
      fair_exp = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
         step("fair");
         chk("fair.idx", {27'd0, out_idx}, fair_exp[i][31:0]);
      end
      do_reset();
      req = 32'h200; out_ready = 1'b0;
      step("lone9");
      req = '0; out_ready = 1'b1;
      step("lone_idle");
      req = 32'h4; out_ready = 1'b0;
      step("lone2");
      chk("lone2.idx", {27'd0, out_idx}, 32'd2);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       req = '0;
            1:       req = 32'd1 << $urandom_range(0, N - 1);
            2:       req = $urandom & $urandom & $urandom;
            default: req = $urandom;
         endcase
         en        = ($urandom_range(0, 3) != 0);
         out_ready = $urandom_range(0, 1) == 1;
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rr_priority_encoder

`default_nettype wire
